// File: rtl/dma_stream_pkg.sv
// Shared definitions for the host/FPGA DMA stream path.
// The C2H packer and the H2C unpacker both use this package.
package dma_stream_pkg;

    localparam int SEQ_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BODY  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_HOLD  = 3'd3
    } rstate_e;

    // Beat 0 carries the sequence byte, so a frame needs room for DATA_WIDTH + 8 bits.
    function automatic int frame_beats(input int data_w, input int axis_w);
        return (data_w + axis_w + 32'sd7) / axis_w + 32'sd1;
    endfunction

endpackage

// File: rtl/axis_frame_assembler.sv
// Counts the beats of one H2C frame and builds its payload word.
// Also classifies the frame length at each accepted beat.
module axis_frame_assembler
    import dma_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       accum_i,
    input  logic [AXIS_DATA_WIDTH-1:0] tdata_i,
    input  logic                       tlast_i,
    output logic [DATA_WIDTH-1:0]      payload_o,
    output logic                       frame_done_o,
    output logic                       short_err_o,
    output logic                       long_err_o
);

    localparam int AW          = AXIS_DATA_WIDTH;
    localparam int FRAME_BEATS = frame_beats(DATA_WIDTH, AXIS_DATA_WIDTH);
    localparam int BUF_W       = FRAME_BEATS * AW - SEQ_W;
    localparam int CNT_W       = $clog2(FRAME_BEATS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BEATS - 1);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_s;

    // Beats enter at the top and shift down, so beat k ends up at bit k*AW-8.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (start_i) begin
            buf_d = {tdata_i[AW-1:SEQ_W], {(BUF_W-AW+SEQ_W){1'b0}}};
            cnt_d = CNT_W'(1);
        end else if (accum_i) begin
            buf_d = {tdata_i, buf_q[BUF_W-1:AW]};
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            buf_d = buf_q;
            cnt_d = cnt_q;
        end
    end

    // Length classification of the beat being accepted this cycle.
    always_comb begin
        idx_s        = start_i ? {CNT_W{1'b0}} : cnt_q;
        short_err_o  = (start_i | accum_i) & tlast_i & (idx_s < LAST_IDX);
        frame_done_o = accum_i & tlast_i & (cnt_q == LAST_IDX);
        long_err_o   = accum_i & ~tlast_i & (cnt_q == LAST_IDX);
    end

    // The next value is exposed so a frame can leave on its final-beat handshake.
    assign payload_o = buf_d[DATA_WIDTH-1:0];

    // Beat counter and placement register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            buf_q <= {BUF_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_data_unpack.sv
// H2C receive path: strips the sequence header and reassembles frames into one word.
// Checks length, tkeep and sequence continuity, reporting errors as one-cycle pulses.
module axis_data_unpack
    import dma_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = 4064,
    parameter int AXIS_DATA_WIDTH = 512
) (
    input  logic                       s_axis_h2c_aclk,
    input  logic                       rst,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_h2c_tdata,
    input  logic [63:0]                s_axis_h2c_tkeep,
    input  logic                       s_axis_h2c_tlast,
    input  logic                       s_axis_h2c_tvalid,
    output logic                       s_axis_h2c_tready,
    output logic [DATA_WIDTH-1:0]      data,
    output logic                       data_valid,
    input  logic                       data_ready,
    output logic [SEQ_W-1:0]           seq,
    output logic                       seq_err,
    output logic                       len_err,
    output logic [31:0]                frame_cnt,
    output logic [2:0]                 rstate
);

    rstate_e                state_q, state_d;
    logic [SEQ_W-1:0]       hdr_q, hdr_d, seq_q, seq_d, exp_seq_q, exp_seq_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d, payload_s;
    logic                   valid_q, valid_d, seq_err_q, seq_err_d, len_err_q, len_err_d;
    logic [31:0]            frame_cnt_q, frame_cnt_d;
    logic                   tready_s, hs_s, keep_ok_s, start_s, accum_s, out_free_s, xfer_s;
    logic                   frame_done_s, short_err_s, long_err_s;

    assign tready_s   = ~rst & (state_q != ST_HOLD);
    assign hs_s       = s_axis_h2c_tvalid & tready_s;
    assign keep_ok_s  = (s_axis_h2c_tkeep == {64{1'b1}});
    assign start_s    = hs_s & keep_ok_s & (state_q == ST_IDLE);
    assign accum_s    = hs_s & keep_ok_s & (state_q == ST_BODY);
    assign out_free_s = ~valid_q | data_ready;

    axis_frame_assembler #(
        .DATA_WIDTH      (DATA_WIDTH),
        .AXIS_DATA_WIDTH (AXIS_DATA_WIDTH)
    ) u_asm (
        .clk_i        (s_axis_h2c_aclk),
        .rst_i        (rst),
        .start_i      (start_s),
        .accum_i      (accum_s),
        .tdata_i      (s_axis_h2c_tdata),
        .tlast_i      (s_axis_h2c_tlast),
        .payload_o    (payload_s),
        .frame_done_o (frame_done_s),
        .short_err_o  (short_err_s),
        .long_err_o   (long_err_s)
    );

    // Frame FSM: next state, length errors and the hand-off into the output register.
    always_comb begin
        state_d   = state_q;
        len_err_d = 1'b0;
        xfer_s    = 1'b0;
        case (state_q)
            ST_IDLE, ST_BODY: begin
                if (!hs_s) begin
                    state_d = state_q;
                end else if (!keep_ok_s) begin
                    len_err_d = 1'b1;
                    state_d   = s_axis_h2c_tlast ? ST_IDLE : ST_DRAIN;
                end else if (short_err_s) begin
                    len_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (long_err_s) begin
                    len_err_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (frame_done_s) begin
                    xfer_s  = out_free_s;
                    state_d = out_free_s ? ST_IDLE : ST_HOLD;
                end else begin
                    state_d = ST_BODY;
                end
            end
            ST_DRAIN: begin
                if (hs_s) begin
                    len_err_d = ~keep_ok_s;
                    state_d   = s_axis_h2c_tlast ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HOLD: begin
                xfer_s  = out_free_s;
                state_d = out_free_s ? ST_IDLE : ST_HOLD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output register, sequence check and delivered-frame counter.
    always_comb begin
        hdr_d       = start_s ? s_axis_h2c_tdata[SEQ_W-1:0] : hdr_q;
        data_d      = data_q;
        seq_d       = seq_q;
        valid_d     = valid_q;
        seq_err_d   = 1'b0;
        exp_seq_d   = exp_seq_q;
        frame_cnt_d = frame_cnt_q;
        if (xfer_s) begin
            data_d      = payload_s;
            seq_d       = hdr_q;
            valid_d     = 1'b1;
            seq_err_d   = (hdr_q != exp_seq_q);
            exp_seq_d   = hdr_q + 8'd1;
            frame_cnt_d = frame_cnt_q + 32'd1;
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge s_axis_h2c_aclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hdr_q       <= 8'd0;
            data_q      <= {DATA_WIDTH{1'b0}};
            seq_q       <= 8'd0;
            valid_q     <= 1'b0;
            seq_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            exp_seq_q   <= 8'd0;
            frame_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            hdr_q       <= hdr_d;
            data_q      <= data_d;
            seq_q       <= seq_d;
            valid_q     <= valid_d;
            seq_err_q   <= seq_err_d;
            len_err_q   <= len_err_d;
            exp_seq_q   <= exp_seq_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_axis_h2c_tready = tready_s;
    assign data              = data_q;
    assign data_valid        = valid_q;
    assign seq               = seq_q;
    assign seq_err           = seq_err_q;
    assign len_err           = len_err_q;
    assign frame_cnt         = frame_cnt_q;
    assign rstate            = state_q;

endmodule

// File: tb/tb_axis_data_unpack.sv
// Directed bench for axis_data_unpack at the default widths (9-beat frames).
module tb_axis_data_unpack;

    localparam int DW  = 4064;
    localparam int AW  = 512;
    localparam int FB  = 9;
    localparam int EXT = FB * AW - 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] tdata = '0;
    logic [63:0]   tkeep = '1;
    logic          tlast = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [DW-1:0] data;
    logic          data_valid;
    logic          data_ready = 1'b1;
    logic [7:0]    seq;
    logic          seq_err, len_err;
    logic [31:0]   frame_cnt;
    logic [2:0]    rstate;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int len_cnt = 0;
    int seq_cnt = 0;
    logic [DW-1:0] got_data[$];
    logic [7:0]    got_seq[$];

    axis_data_unpack dut (
        .s_axis_h2c_aclk   (clk),
        .rst               (rst),
        .s_axis_h2c_tdata  (tdata),
        .s_axis_h2c_tkeep  (tkeep),
        .s_axis_h2c_tlast  (tlast),
        .s_axis_h2c_tvalid (tvalid),
        .s_axis_h2c_tready (tready),
        .data              (data),
        .data_valid        (data_valid),
        .data_ready        (data_ready),
        .seq               (seq),
        .seq_err           (seq_err),
        .len_err           (len_err),
        .frame_cnt         (frame_cnt),
        .rstate            (rstate)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records deliveries and error pulses mid-cycle.
    always @(negedge clk) begin
        if (data_valid && data_ready) begin
            got_data.push_back(data);
            got_seq.push_back(seq);
        end
        if (len_err) len_cnt <= len_cnt + 1;
        if (seq_err) seq_cnt <= seq_cnt + 1;
    end

    function automatic logic [DW-1:0] make_payload(input logic [7:0] tag);
        logic [DW-1:0] p;
        for (int i = 0; i < DW / 32; i++) p[i*32 +: 32] = {tag, 24'(i)};
        return p;
    endfunction

    // Beat k of a frame; padding past DW is filled with ones.
    function automatic logic [AW-1:0] beat_of(input logic [7:0] hdr, input logic [DW-1:0] p, input int k);
        logic [EXT-1:0] ext;
        ext = {{(EXT-DW){1'b1}}, p};
        if (k == 0) return {ext[AW-9:0], hdr};
        else if (k < FB) return ext[k*AW-8 +: AW];
        else return {(AW/32){32'hA5A5_0000 + 32'(k)}};
    endfunction

    task automatic send_beat(input logic [AW-1:0] d, input logic [63:0] k, input logic l);
        bit ok;
        int budget;
        tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
        ok = 1'b0; budget = 0;
        while (!ok && budget < 200) begin
            @(negedge clk); ok = tready;
            @(posedge clk); #1;
            budget++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: tready got 0 expected 1 within 200 cycles");
        end
    endtask

    task automatic bus_idle();
        tvalid = 1'b0; tlast = 1'b0; tkeep = '1;
    endtask

    task automatic send_frame(input logic [7:0] hdr, input logic [DW-1:0] p);
        for (int k = 0; k < FB; k++) send_beat(beat_of(hdr, p, k), '1, k == FB - 1);
    endtask

    task automatic do_reset();
        bus_idle();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        got_data.delete(); got_seq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b expected 0", tready); end
        n_cmp++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", data_valid); end
        n_cmp++; if (data !== '0) begin n_err++; $display("FAIL rst_data: got %h expected 0", data[127:0]); end
        n_cmp++; if (seq !== 8'd0) begin n_err++; $display("FAIL rst_seq: got %0d expected 0", seq); end
        n_cmp++; if ({seq_err, len_err} !== 2'b00) begin n_err++; $display("FAIL rst_errs: got %b expected 00", {seq_err, len_err}); end
        n_cmp++; if (frame_cnt !== 32'd0) begin n_err++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
        n_cmp++; if (rstate !== 3'd0) begin n_err++; $display("FAIL rst_rstate: got %0d expected 0", rstate); end
        rst = 1'b0;
        #1;
        n_cmp++; if (tready !== 1'b1) begin n_err++; $display("FAIL rst_release_tready: got %b expected 1", tready); end
    endtask

    task automatic test_back_to_back();
        int c0, l0, s0;
        logic [DW-1:0] p[3];
        do_reset();
        data_ready = 1'b1;
        l0 = len_cnt; s0 = seq_cnt; c0 = cyc;
        for (int f = 0; f < 3; f++) begin
            p[f] = make_payload(8'(8'h10 + f));
            send_frame(8'(f), p[f]);
            if (f == 0) begin
                n_cmp++; if (data_valid !== 1'b1) begin n_err++; $display("FAIL b2b_latency: data_valid got %b expected 1", data_valid); end
            end
        end
        n_cmp++; if (cyc - c0 !== 3 * FB) begin n_err++; $display("FAIL b2b_cycles: got %0d expected %0d", cyc - c0, 3 * FB); end
        bus_idle();
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 3) begin n_err++; $display("FAIL b2b_count: got %0d expected 3", got_data.size()); end
        for (int f = 0; f < 3; f++) begin
            n_cmp++; if (got_data[f] !== p[f]) begin n_err++; $display("FAIL b2b_data%0d: got %h expected %h", f, got_data[f][127:0], p[f][127:0]); end
            n_cmp++; if (got_seq[f] !== 8'(f)) begin n_err++; $display("FAIL b2b_seq%0d: got %0d expected %0d", f, got_seq[f], f); end
        end
        n_cmp++; if (len_cnt - l0 + seq_cnt - s0 !== 0) begin n_err++; $display("FAIL b2b_errors: got %0d expected 0", len_cnt - l0 + seq_cnt - s0); end
        n_cmp++; if (frame_cnt !== 32'd3) begin n_err++; $display("FAIL b2b_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_short();
        int l0, s0;
        logic [DW-1:0] p;
        do_reset();
        data_ready = 1'b1;
        p = make_payload(8'h21);
        l0 = len_cnt; s0 = seq_cnt;
        for (int k = 0; k < 5; k++) send_beat(beat_of(8'd0, p, k), '1, k == 4);
        bus_idle();
        n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL short_len_err: got %b expected 1", len_err); end
        n_cmp++; if (rstate !== 3'd0) begin n_err++; $display("FAIL short_rstate: got %0d expected 0", rstate); end
        p = make_payload(8'h22);
        send_frame(8'd0, p);
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 1) begin n_err++; $display("FAIL short_count: got %0d expected 1", got_data.size()); end
        n_cmp++; if (got_data[0] !== p) begin n_err++; $display("FAIL short_data: got %h expected %h", got_data[0][127:0], p[127:0]); end
        n_cmp++; if (len_cnt - l0 !== 1) begin n_err++; $display("FAIL short_len_pulses: got %0d expected 1", len_cnt - l0); end
        n_cmp++; if (seq_cnt - s0 !== 0) begin n_err++; $display("FAIL short_seq_err: got %0d expected 0", seq_cnt - s0); end
        n_cmp++; if (frame_cnt !== 32'd1) begin n_err++; $display("FAIL short_frame_cnt: got %0d expected 1", frame_cnt); end
    endtask

    task automatic test_long();
        int l0;
        logic [DW-1:0] p;
        do_reset();
        data_ready = 1'b1;
        p = make_payload(8'h31);
        l0 = len_cnt;
        for (int k = 0; k < 12; k++) begin
            send_beat(beat_of(8'd0, p, k), '1, k == 11);
            if (k == 8) begin
                n_cmp++; if (len_err !== 1'b1) begin n_err++; $display("FAIL long_len_err: got %b expected 1", len_err); end
                n_cmp++; if (rstate !== 3'd2) begin n_err++; $display("FAIL long_drain8: got %0d expected 2", rstate); end
            end
            if (k == 10) begin
                n_cmp++; if (rstate !== 3'd2) begin n_err++; $display("FAIL long_drain10: got %0d expected 2", rstate); end
            end
        end
        bus_idle();
        n_cmp++; if (rstate !== 3'd0) begin n_err++; $display("FAIL long_idle: got %0d expected 0", rstate); end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 0) begin n_err++; $display("FAIL long_no_output: got %0d expected 0", got_data.size()); end
        n_cmp++; if (len_cnt - l0 !== 1) begin n_err++; $display("FAIL long_len_pulses: got %0d expected 1", len_cnt - l0); end
    endtask

    task automatic test_bad_keep();
        int l0;
        logic [DW-1:0] p;
        do_reset();
        data_ready = 1'b1;
        p = make_payload(8'h41);
        l0 = len_cnt;
        for (int k = 0; k < FB; k++) begin
            send_beat(beat_of(8'd0, p, k), (k == 2) ? 64'hFFFF_FFFF_FFFF_FFFE : 64'hFFFF_FFFF_FFFF_FFFF, k == FB - 1);
            if (k == 2) begin
                n_cmp++; if ({len_err, rstate} !== 4'b1_010) begin n_err++; $display("FAIL keep_drain: got %b expected 1010", {len_err, rstate}); end
            end
        end
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 0 || rstate !== 3'd0) begin n_err++; $display("FAIL keep_dropped: outputs %0d state %0d expected 0 0", got_data.size(), rstate); end
        n_cmp++; if (len_cnt - l0 !== 1) begin n_err++; $display("FAIL keep_len_pulses: got %0d expected 1", len_cnt - l0); end
    endtask

    task automatic test_seq_gap();
        int s0;
        logic [7:0] hdr[3];
        hdr[0] = 8'd0; hdr[1] = 8'd5; hdr[2] = 8'd6;
        do_reset();
        data_ready = 1'b1;
        s0 = seq_cnt;
        for (int f = 0; f < 3; f++) begin
            send_frame(hdr[f], make_payload(8'(8'h50 + f)));
            bus_idle();
            n_cmp++; if (seq_err !== (f == 1)) begin n_err++; $display("FAIL gap_seq_err%0d: got %b expected %b", f, seq_err, f == 1); end
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 3) begin n_err++; $display("FAIL gap_count: got %0d expected 3", got_data.size()); end
        for (int f = 0; f < 3; f++) begin
            n_cmp++; if (got_seq[f] !== hdr[f]) begin n_err++; $display("FAIL gap_seq%0d: got %0d expected %0d", f, got_seq[f], hdr[f]); end
        end
        n_cmp++; if (seq_cnt - s0 !== 1) begin n_err++; $display("FAIL gap_pulses: got %0d expected 1", seq_cnt - s0); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] pa, pb;
        do_reset();
        data_ready = 1'b0;
        pa = make_payload(8'h61);
        pb = make_payload(8'h62);
        send_frame(8'd0, pa);
        send_frame(8'd1, pb);
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (rstate !== 3'd3) begin n_err++; $display("FAIL bp_hold: got %0d expected 3", rstate); end
        n_cmp++; if (tready !== 1'b0) begin n_err++; $display("FAIL bp_tready: got %b expected 0", tready); end
        n_cmp++; if (data_valid !== 1'b1 || seq !== 8'd0) begin n_err++; $display("FAIL bp_out: valid %b seq %0d expected 1 0", data_valid, seq); end
        n_cmp++; if (data !== pa) begin n_err++; $display("FAIL bp_data: got %h expected %h", data[127:0], pa[127:0]); end
        data_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 2) begin n_err++; $display("FAIL bp_count: got %0d expected 2", got_data.size()); end
        n_cmp++; if (got_data[0] !== pa || got_seq[0] !== 8'd0) begin n_err++; $display("FAIL bp_first: got seq %0d data %h expected seq 0 data %h", got_seq[0], got_data[0][127:0], pa[127:0]); end
        n_cmp++; if (got_data[1] !== pb || got_seq[1] !== 8'd1) begin n_err++; $display("FAIL bp_second: got seq %0d data %h expected seq 1 data %h", got_seq[1], got_data[1][127:0], pb[127:0]); end
        n_cmp++; if ({data_valid, rstate} !== 4'b0_000) begin n_err++; $display("FAIL bp_drained: got %b expected 0000", {data_valid, rstate}); end
        n_cmp++; if (frame_cnt !== 32'd2) begin n_err++; $display("FAIL bp_frame_cnt: got %0d expected 2", frame_cnt); end
    endtask

    task automatic test_reset_mid();
        int s0;
        logic [DW-1:0] pa, pc;
        do_reset();
        data_ready = 1'b0;
        pa = make_payload(8'h71);
        send_frame(8'd0, pa);
        for (int k = 0; k < 3; k++) send_beat(beat_of(8'd1, pa, k), '1, 1'b0);
        tdata = beat_of(8'd1, pa, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({tready, data_valid, seq_err, len_err} !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b expected 0000", {tready, data_valid, seq_err, len_err}); end
        n_cmp++; if (data !== '0 || seq !== 8'd0) begin n_err++; $display("FAIL mid_data: got seq %0d data %h expected 0 0", seq, data[127:0]); end
        n_cmp++; if (frame_cnt !== 32'd0 || rstate !== 3'd0) begin n_err++; $display("FAIL mid_cnt_state: got %0d %0d expected 0 0", frame_cnt, rstate); end
        rst = 1'b0;
        bus_idle();
        data_ready = 1'b1;
        got_data.delete(); got_seq.delete();
        s0 = seq_cnt;
        pc = make_payload(8'h72);
        send_frame(8'd0, pc);
        bus_idle();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (got_data.size() !== 1) begin n_err++; $display("FAIL mid_count: got %0d expected 1", got_data.size()); end
        n_cmp++; if (got_data[0] !== pc || got_seq[0] !== 8'd0) begin n_err++; $display("FAIL mid_frame: got seq %0d data %h expected seq 0 data %h", got_seq[0], got_data[0][127:0], pc[127:0]); end
        n_cmp++; if (seq_cnt - s0 !== 0 || frame_cnt !== 32'd1) begin n_err++; $display("FAIL mid_after: seq_err %0d frame_cnt %0d expected 0 1", seq_cnt - s0, frame_cnt); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_short();
        test_long();
        test_bad_keep();
        test_seq_gap();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
